// File: rtl/house_score_bcd.sv
// Four house point totals, each with a saturating add/deduct lane, plus a shared
// double-dabble engine that refreshes a per-house BCD cache for the leaderboard.

module house_score_lane #(
   parameter int SCORE_W   = 20,
   parameter int PTS_W     = 8,
   parameter int MAX_SCORE = 999999
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               upd,
   input  logic               deduct,
   input  logic [PTS_W-1:0]   amt,
   output logic [SCORE_W-1:0] score
);
   localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W+1)'(MAX_SCORE);

   logic [SCORE_W:0] amt_ext, sum, diff;

   // One extra bit keeps the carry/borrow so clamping sees the true result
   assign amt_ext = (SCORE_W+1)'(amt);
   assign sum     = {1'b0, score} + amt_ext;
   assign diff    = {1'b0, score} - amt_ext;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         score <= '0;
      else if (clear)
         score <= '0;
      else if (upd) begin
         if (deduct)
            score <= diff[SCORE_W] ? '0 : diff[SCORE_W-1:0];
         else
            score <= (sum > MAX_EXT) ? MAX_EXT[SCORE_W-1:0] : sum[SCORE_W-1:0];
      end
   end
endmodule

module house_score_bcd #(
   parameter int SCORE_W   = 20,
   parameter int PTS_W     = 8,
   parameter int MAX_SCORE = 999999
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pts_en,
   input  logic [1:0]       pts_house,
   input  logic             pts_deduct,
   input  logic [PTS_W-1:0] pts_amt,
   input  logic             clear_scores,
   input  logic [1:0]       rd_house,
   input  logic [2:0]       rd_digit,
   output logic [3:0]       digit_val,
   output logic             digit_blank,
   output logic [1:0]       leader,
   output logic             busy
);
   localparam int NUM_HOUSES = 4;
   localparam int BCD_W      = 24;
   localparam int CNT_W      = $clog2(SCORE_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_STORE} state_t;

   state_t                                 state, state_nx;
   logic [NUM_HOUSES-1:0][SCORE_W-1:0]     score;
   logic [NUM_HOUSES-1:0][BCD_W-1:0]       cache;
   logic [NUM_HOUSES-1:0]                  dirty, dirty_nx;
   logic [1:0]                             cur, last, pick, pick_idx, best;
   logic                                   pick_vld;
   logic [SCORE_W-1:0]                     bin;
   logic [BCD_W-1:0]                       acc, acc_adj, rd_sel, rd_upper;
   logic [CNT_W-1:0]                       cnt;
   logic [2:0]                             rd_idx;
   logic [3:0]                             val_c;
   logic                                   blank_c;

   for (genvar g = 0; g < NUM_HOUSES; g++) begin : g_lane
      house_score_lane #(
         .SCORE_W   (SCORE_W),
         .PTS_W     (PTS_W),
         .MAX_SCORE (MAX_SCORE)
      ) u_lane (
         .clk    (clk),
         .reset  (reset),
         .clear  (clear_scores),
         .upd    (pts_en && (pts_house == 2'(g))),
         .deduct (pts_deduct),
         .amt    (pts_amt),
         .score  (score[g])
      );
   end

   // Round-robin: nearest dirty house after the last one converted wins
   always_comb begin
      pick     = last + 2'd1;
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int k = NUM_HOUSES; k >= 1; k--) begin
         pick_idx = last + 2'(k);
         if (dirty[pick_idx]) begin
            pick     = pick_idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (pick_vld) state_nx = S_LOAD;
         S_LOAD:  state_nx = S_SHIFT;
         S_SHIFT: if (cnt == CNT_W'(SCORE_W - 1)) state_nx = S_STORE;
         S_STORE: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
      if (clear_scores) state_nx = S_IDLE;
   end

   // An update landing in LOAD re-sets the bit after the clear, forcing a redo
   always_comb begin
      dirty_nx = dirty;
      if (state == S_LOAD) dirty_nx[cur] = 1'b0;
      if (pts_en) dirty_nx[pts_house] = 1'b1;
      if (clear_scores) dirty_nx = '1;
   end

   always_comb begin
      acc_adj = acc;
      for (int n = 0; n < BCD_W / 4; n++)
         if (acc[4*n +: 4] >= 4'd5) acc_adj[4*n +: 4] = acc[4*n +: 4] + 4'd3;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         dirty <= '0;
         cur   <= '0;
         last  <= 2'd3;
         bin   <= '0;
         acc   <= '0;
         cnt   <= '0;
         cache <= '0;
      end else begin
         state <= state_nx;
         dirty <= dirty_nx;
         case (state)
            S_IDLE: if (pick_vld) cur <= pick;
            S_LOAD: begin
               bin <= score[cur];
               acc <= '0;
               cnt <= '0;
            end
            S_SHIFT: begin
               acc <= {acc_adj[BCD_W-2:0], bin[SCORE_W-1]};
               bin <= bin << 1;
               cnt <= cnt + 1'b1;
            end
            S_STORE: if (!clear_scores) begin
               cache[cur] <= acc;
               last       <= cur;
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != S_IDLE);

   // Blank when every cached digit at or above this position is zero
   always_comb begin
      rd_sel   = cache[rd_house];
      rd_idx   = rd_digit - 3'd1;
      rd_upper = rd_sel >> {rd_idx, 2'b00};
      val_c    = 4'd0;
      blank_c  = 1'b1;
      if (rd_digit != 3'd0 && rd_digit != 3'd7) begin
         val_c   = rd_upper[3:0];
         blank_c = (rd_idx != 3'd0) && (rd_upper == '0);
      end
   end

   always_comb begin
      best = 2'd0;
      for (int k = 1; k < NUM_HOUSES; k++)
         if (score[k] > score[best]) best = 2'(k);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digit_val   <= '0;
         digit_blank <= 1'b1;
         leader      <= '0;
      end else begin
         digit_val   <= val_c;
         digit_blank <= blank_c;
         leader      <= best;
      end
   end
endmodule

// File: tb/tb_house_score_bcd.sv
// Directed bench: a default instance and a MAX_SCORE=1000 instance share stimulus.

module tb_house_score_bcd;
   logic       clk = 1'b0;
   logic       reset;
   logic       pts_en, pts_deduct, clear_scores;
   logic [1:0] pts_house, rd_house;
   logic [7:0] pts_amt;
   logic [2:0] rd_digit;
   logic [3:0] digit_val, s_digit_val;
   logic       digit_blank, s_digit_blank, busy, s_busy;
   logic [1:0] leader, s_leader;

   int n_chk = 0;
   int n_fail = 0;
   logic [3:0] rv, sv;
   logic       rb, sb;
   logic       saw_old, saw_new;

   always #5 clk = ~clk;

   house_score_bcd dut (
      .clk(clk), .reset(reset), .pts_en(pts_en), .pts_house(pts_house),
      .pts_deduct(pts_deduct), .pts_amt(pts_amt), .clear_scores(clear_scores),
      .rd_house(rd_house), .rd_digit(rd_digit), .digit_val(digit_val),
      .digit_blank(digit_blank), .leader(leader), .busy(busy)
   );

   house_score_bcd #(.MAX_SCORE(1000)) dut_sat (
      .clk(clk), .reset(reset), .pts_en(pts_en), .pts_house(pts_house),
      .pts_deduct(pts_deduct), .pts_amt(pts_amt), .clear_scores(clear_scores),
      .rd_house(rd_house), .rd_digit(rd_digit), .digit_val(s_digit_val),
      .digit_blank(s_digit_blank), .leader(s_leader), .busy(s_busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic upd(input logic [1:0] h, input logic [7:0] amt, input logic ded);
      pts_en = 1'b1; pts_house = h; pts_amt = amt; pts_deduct = ded;
      tick();
      pts_en = 1'b0; pts_deduct = 1'b0;
   endtask

   task automatic rd(input logic [1:0] h, input logic [2:0] p);
      rd_house = h; rd_digit = p;
      tick();
      rv = digit_val; rb = digit_blank; sv = s_digit_val; sb = s_digit_blank;
   endtask

   initial begin
      reset = 1'b1; pts_en = 0; pts_deduct = 0; clear_scores = 0;
      pts_house = 0; pts_amt = 0; rd_house = 0; rd_digit = 0;
      settle(3);
      chk("rst_val", digit_val, 0);
      chk("rst_blank", digit_blank, 1);
      chk("rst_leader", leader, 0);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      // G = 600
      for (int i = 0; i < 3; i++) upd(2'd0, 8'd200, 1'b0);
      settle(100);
      rd(2'd0, 3'd3); chk("t1_g3_val", rv, 6); chk("t1_g3_blank", rb, 0);
      rd(2'd0, 3'd1); chk("t1_g1_val", rv, 0); chk("t1_g1_blank", rb, 0);
      rd(2'd0, 3'd2); chk("t1_g2_blank", rb, 0);
      rd(2'd0, 3'd4); chk("t1_g4_blank", rb, 1);
      chk("t1_leader", leader, 0);

      // H = 10 then deduct 25 floors at 0
      upd(2'd3, 8'd10, 1'b0);
      upd(2'd3, 8'd25, 1'b1);
      settle(100);
      rd(2'd3, 3'd1); chk("t2_h1_val", rv, 0); chk("t2_h1_blank", rb, 0);
      rd(2'd3, 3'd2); chk("t2_h2_blank", rb, 1);
      rd(2'd0, 3'd0); chk("t2_pos0_val", rv, 0); chk("t2_pos0_blank", rb, 1);
      rd(2'd0, 3'd7); chk("t2_pos7_blank", rb, 1);

      // R += 255 x5: 1275 unclamped, 1000 on the saturating instance
      for (int i = 0; i < 5; i++) upd(2'd2, 8'd255, 1'b0);
      settle(100);
      rd(2'd2, 3'd1); chk("t3_r1", rv, 5); chk("t3_sat_r1", sv, 0); chk("t3_sat_r1_blank", sb, 0);
      rd(2'd2, 3'd2); chk("t3_r2", rv, 7); chk("t3_sat_r2", sv, 0);
      rd(2'd2, 3'd3); chk("t3_r3", rv, 2); chk("t3_sat_r3", sv, 0);
      rd(2'd2, 3'd4); chk("t3_r4", rv, 1); chk("t3_sat_r4", sv, 1); chk("t3_sat_r4_blank", sb, 0);
      rd(2'd2, 3'd5); chk("t3_r5_blank", rb, 1); chk("t3_sat_r5_blank", sb, 1);
      chk("t3_leader", leader, 2);
      chk("t3_sat_leader", s_leader, 2);

      // clear beats a simultaneous update
      pts_en = 1'b1; pts_house = 2'd1; pts_amt = 8'd50; clear_scores = 1'b1;
      tick();
      pts_en = 1'b0; clear_scores = 1'b0;
      settle(100);
      chk("t4_busy", busy, 0);
      rd(2'd0, 3'd3); chk("t4_g3_val", rv, 0); chk("t4_g3_blank", rb, 1);
      rd(2'd2, 3'd4); chk("t4_r4_blank", rb, 1);
      rd(2'd1, 3'd2); chk("t4_s2_blank", rb, 1);
      rd(2'd1, 3'd1); chk("t4_s1_val", rv, 0);
      chk("t4_leader", leader, 0);

      // update mid-SHIFT: first store keeps 105, a rerun gives 112
      upd(2'd0, 8'd100, 1'b0);
      settle(60);
      rd_house = 2'd0; rd_digit = 3'd1;
      upd(2'd0, 8'd5, 1'b0);
      settle(11);
      chk("t5_busy_shift", busy, 1);
      upd(2'd0, 8'd7, 1'b0);
      chk("t5_pre_store", digit_val, 0);
      saw_old = 1'b0; saw_new = 1'b0;
      for (int i = 0; i < 80; i++) begin
         tick();
         if (digit_val == 4'd5 && !saw_new) saw_old = 1'b1;
         if (digit_val == 4'd2) saw_new = 1'b1;
      end
      chk("t5_saw_old", saw_old, 1);
      chk("t5_saw_new", saw_new, 1);
      rd(2'd0, 3'd2); chk("t5_g2", rv, 1);
      rd(2'd0, 3'd3); chk("t5_g3", rv, 1);
      rd(2'd0, 3'd4); chk("t5_g4_blank", rb, 1);

      // tie goes to lower index, then S pulls ahead
      upd(2'd0, 8'd188, 1'b0);
      upd(2'd1, 8'd200, 1'b0);
      upd(2'd1, 8'd100, 1'b0);
      settle(2);
      chk("t6_tie_leader", leader, 0);
      upd(2'd1, 8'd1, 1'b0);
      settle(100);
      chk("t6_leader_s", leader, 1);
      rd(2'd0, 3'd3); chk("t6_g3_pre", rv, 3);

      // async reset in the middle of a conversion
      upd(2'd3, 8'd9, 1'b0);
      settle(4);
      chk("t6_busy_pre", busy, 1);
      reset = 1'b1;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_val", digit_val, 0);
      chk("t6_rst_blank", digit_blank, 1);
      chk("t6_rst_leader", leader, 0);
      #6;
      reset = 1'b0;
      settle(30);
      chk("t6_idle_after", busy, 0);
      rd(2'd0, 3'd3); chk("t6_g3_cleared", rv, 0); chk("t6_g3_blank", rb, 1);
      rd(2'd3, 3'd1); chk("t6_h1", rv, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
